// File: rtl/vc_mem_test_nport.sv
// Multi-port test memory with per-port request sequencers, optional random
// per-request delay and a single round-robin-arbitrated word array.
//
// Per-port FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | ready for a request; latches fields and loads delay count
//   ST_WAIT | counting down delay, then requesting the array until granted
//   ST_RESP | read data valid, held until the consumer accepts it
module vc_mem_test_nport #(
    parameter int          NUM_PORTS  = 2,
    parameter int          MEM_SZ     = 8,
    parameter int          ADDR_SZ    = 32,
    parameter int          DATA_SZ    = 32,
    parameter int          ADDR_SHIFT = 2,
    parameter int          MAX_DELAY  = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           memreq_bits_rw,
    input  logic [NUM_PORTS*ADDR_SZ-1:0]   memreq_bits_addr,
    input  logic [NUM_PORTS*DATA_SZ-1:0]   memreq_bits_data,
    input  logic [NUM_PORTS*DATA_SZ/8-1:0] memreq_bits_wmask,
    input  logic [NUM_PORTS-1:0]           memreq_val,
    output logic [NUM_PORTS-1:0]           memreq_rdy,
    output logic [NUM_PORTS*DATA_SZ-1:0]   memresp_bits_data,
    output logic [NUM_PORTS-1:0]           memresp_val,
    input  logic [NUM_PORTS-1:0]           memresp_rdy
);

    localparam int IDX_W = MEM_SZ - ADDR_SHIFT;
    localparam int DEPTH = 1 << IDX_W;
    localparam int NB    = DATA_SZ / 8;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q [NUM_PORTS];
    logic               rw_q    [NUM_PORTS];
    logic [IDX_W-1:0]   idx_q   [NUM_PORTS];
    logic [DATA_SZ-1:0] wdata_q [NUM_PORTS];
    logic [NB-1:0]      wmask_q [NUM_PORTS];
    logic [15:0]        cnt_q   [NUM_PORTS];
    logic [15:0]        lfsr_q  [NUM_PORTS];
    logic [DATA_SZ-1:0] rdata_q [NUM_PORTS];

    logic [DATA_SZ-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] gnt;
    logic                 gnt_any;
    logic [PW-1:0]        gnt_idx;
    logic [PW-1:0]        arb_p;
    logic [PW-1:0]        rr_q;

    logic               wr_rw;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_SZ-1:0] wr_data;
    logic [NB-1:0]      wr_mask;
    logic [DATA_SZ-1:0] wr_bmask;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^memreq_bits_addr;

    // Galois right-shift form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] delay_of(input logic [15:0] x);
        if (MAX_DELAY == 0) return 16'd0;
        return 16'((32'(x)) % (32'(MAX_DELAY + 1)));
    endfunction

    // Round-robin pick among ports whose delay has expired, searching from rr_q.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        arb_p   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            arb_p = PW'((int'(rr_q) + i) % NUM_PORTS);
            if (!gnt_any && arb_req[arb_p]) begin
                gnt_any      = 1'b1;
                gnt_idx      = arb_p;
                gnt[arb_p]   = 1'b1;
            end
        end
    end

    // Search restarts at the port after the one just granted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q <= '0;
        end else if (gnt_any) begin
            rr_q <= PW'((int'(gnt_idx) + 1) % NUM_PORTS);
        end
    end

    // Steer the granted port's write fields toward the array.
    always_comb begin
        wr_rw   = rw_q[gnt_idx];
        wr_idx  = idx_q[gnt_idx];
        wr_data = wdata_q[gnt_idx];
        wr_mask = wmask_q[gnt_idx];
    end

    for (genvar b = 0; b < NB; b++) begin : g_bmask
        assign wr_bmask[b*8 +: 8] = {8{wr_mask[b]}};
    end

    // Byte-masked array write; gated by reset so a dropped request never lands.
    always_ff @(posedge clk) begin
        if (reset_n && gnt_any && wr_rw) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_bmask) | (wr_data & wr_bmask);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign arb_req[p]     = (state_q[p] == ST_WAIT) && (cnt_q[p] == 16'd0);
        assign memreq_rdy[p]  = (state_q[p] == ST_IDLE);
        assign memresp_val[p] = (state_q[p] == ST_RESP);
        assign memresp_bits_data[p*DATA_SZ +: DATA_SZ] = rdata_q[p];

        // Per-port request sequencer: accept, delay, arbitrate, respond.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q[p] <= ST_IDLE;
                rw_q[p]    <= 1'b0;
                idx_q[p]   <= '0;
                wdata_q[p] <= '0;
                wmask_q[p] <= '0;
                cnt_q[p]   <= 16'd0;
                lfsr_q[p]  <= LFSR_SEED ^ 16'(p);
                rdata_q[p] <= '0;
            end else begin
                case (state_q[p])
                    ST_IDLE: begin
                        if (memreq_val[p]) begin
                            rw_q[p]    <= memreq_bits_rw[p];
                            idx_q[p]   <= memreq_bits_addr[p*ADDR_SZ + ADDR_SHIFT +: IDX_W];
                            wdata_q[p] <= memreq_bits_data[p*DATA_SZ +: DATA_SZ];
                            wmask_q[p] <= memreq_bits_wmask[p*NB +: NB];
                            cnt_q[p]   <= delay_of(lfsr_q[p]);
                            lfsr_q[p]  <= lfsr_next(lfsr_q[p]);
                            state_q[p] <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q[p] != 16'd0) begin
                            cnt_q[p] <= cnt_q[p] - 16'd1;
                        end else if (gnt[p]) begin
                            if (rw_q[p]) begin
                                state_q[p] <= ST_IDLE;
                            end else begin
                                rdata_q[p] <= mem[idx_q[p]];
                                state_q[p] <= ST_RESP;
                            end
                        end
                    end
                    ST_RESP: begin
                        if (memresp_rdy[p]) begin
                            state_q[p] <= ST_IDLE;
                        end
                    end
                    default: state_q[p] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vc_mem_test_nport.sv
// Directed bench for vc_mem_test_nport: one instance with no delay for exact
// latency/arbitration checks, one with MAX_DELAY=7 for bounded random traffic.
module tb_vc_mem_test_nport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, b_rst_n;
    logic [1:0]  a_rw, a_val, a_req_rdy, a_resp_val, a_resp_rdy;
    logic [63:0] a_addr, a_data, a_resp_data;
    logic [7:0]  a_wmask;
    logic [1:0]  b_rw, b_val, b_req_rdy, b_resp_val, b_resp_rdy;
    logic [63:0] b_addr, b_data, b_resp_data;
    logic [7:0]  b_wmask;

    vc_mem_test_nport #(.NUM_PORTS(2), .MAX_DELAY(0)) dut0 (
        .clk(clk), .reset_n(a_rst_n),
        .memreq_bits_rw(a_rw), .memreq_bits_addr(a_addr),
        .memreq_bits_data(a_data), .memreq_bits_wmask(a_wmask),
        .memreq_val(a_val), .memreq_rdy(a_req_rdy),
        .memresp_bits_data(a_resp_data), .memresp_val(a_resp_val),
        .memresp_rdy(a_resp_rdy)
    );

    vc_mem_test_nport #(.NUM_PORTS(2), .MAX_DELAY(7)) dut7 (
        .clk(clk), .reset_n(b_rst_n),
        .memreq_bits_rw(b_rw), .memreq_bits_addr(b_addr),
        .memreq_bits_data(b_data), .memreq_bits_wmask(b_wmask),
        .memreq_val(b_val), .memreq_rdy(b_req_rdy),
        .memresp_bits_data(b_resp_data), .memresp_val(b_resp_val),
        .memresp_rdy(b_resp_rdy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic a_setup(input int p, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] wm);
        a_rw[p]           = rw;
        a_addr[p*32 +: 32] = addr;
        a_data[p*32 +: 32] = data;
        a_wmask[p*4 +: 4]  = wm;
        a_val[p]          = 1'b1;
    endtask

    // Returns just after the accepting clock edge.
    task automatic a_issue(input int p, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] wm);
        logic got;
        @(negedge clk);
        a_setup(p, rw, addr, data, wm);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (a_req_rdy[p]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_wait", 64'(got), 64'd1);
        @(posedge clk);
        #1 a_val[p] = 1'b0;
    endtask

    task automatic a_wait_resp(input int p, output int lat, output logic [31:0] d);
        lat = -1;
        d   = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_resp_val[p]) begin
                lat = k;
                d   = a_resp_data[p*32 +: 32];
                break;
            end
        end
    endtask

    task automatic a_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] wm);
        a_issue(p, 1'b1, addr, data, wm);
        repeat (2) begin
            @(negedge clk);
            chk("wr_no_resp", 64'(a_resp_val[p]), 64'd0);
        end
        chk("wr_back_idle", 64'(a_req_rdy[p]), 64'd1);
    endtask

    task automatic a_read_chk(input int p, input logic [31:0] addr, input logic [31:0] exp);
        int lat;
        logic [31:0] d;
        a_issue(p, 1'b0, addr, 32'h0, 4'h0);
        a_wait_resp(p, lat, d);
        chk("rd_lat", 64'(lat), 64'd2);
        chk("rd_data", 64'(d), 64'(exp));
    endtask

    task automatic a_dual(input logic [31:0] ad0, input logic [31:0] ad1,
                          output int l0, output int l1,
                          output logic [31:0] d0, output logic [31:0] d1);
        @(negedge clk);
        chk("dual_idle", 64'(a_req_rdy), 64'd3);
        a_setup(0, 1'b0, ad0, 32'h0, 4'h0);
        a_setup(1, 1'b0, ad1, 32'h0, 4'h0);
        @(posedge clk);
        #1 a_val = 2'b00;
        l0 = -1; l1 = -1; d0 = '0; d1 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (l0 < 0 && a_resp_val[0]) begin l0 = k; d0 = a_resp_data[31:0];  end
            if (l1 < 0 && a_resp_val[1]) begin l1 = k; d1 = a_resp_data[63:32]; end
            if (l0 > 0 && l1 > 0) break;
        end
    endtask

    task automatic a_reset_release_chk();
        @(negedge clk);
        a_rst_n = 1'b1;
        chk("rst_req_rdy", 64'(a_req_rdy), 64'd3);
        chk("rst_resp_val", 64'(a_resp_val), 64'd0);
        chk("rst_resp_data", a_resp_data, 64'd0);
    endtask

    logic [31:0] mdl  [64];
    logic [3:0]  mvld [64];

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, lat;
        logic [31:0] d0, d1, d;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_rw = '0; a_val = '0; a_addr = '0; a_data = '0; a_wmask = '0; a_resp_rdy = 2'b11;
        b_rw = '0; b_val = '0; b_addr = '0; b_data = '0; b_wmask = '0; b_resp_rdy = 2'b11;
        repeat (3) @(negedge clk);
        b_rst_n = 1'b1;
        a_reset_release_chk();

        // Full-word write then read, minimum latency.
        a_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        a_read_chk(0, 32'h10, 32'hDEADBEEF);

        // Byte-masked merge.
        a_write(0, 32'h20, 32'h11223344, 4'hF);
        a_write(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        a_read_chk(0, 32'h20, 32'h11BB33DD);

        // Backpressure: response held while memresp_rdy is low.
        @(negedge clk);
        a_resp_rdy[0] = 1'b0;
        a_issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        a_wait_resp(0, lat, d);
        chk("bp_lat", 64'(lat), 64'd2);
        chk("bp_data", 64'(d), 64'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_val_hold", 64'(a_resp_val[0]), 64'd1);
            chk("bp_data_hold", 64'(a_resp_data[31:0]), 64'hDEADBEEF);
            chk("bp_req_rdy_low", 64'(a_req_rdy[0]), 64'd0);
        end
        a_resp_rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_req_rdy_back", 64'(a_req_rdy[0]), 64'd1);
        chk("bp_val_drop", 64'(a_resp_val[0]), 64'd0);
        chk("bp_data_kept", 64'(a_resp_data[31:0]), 64'hDEADBEEF);

        // Reset while a write is pending in WAIT: write and response dropped.
        a_issue(0, 1'b1, 32'h10, 32'h0, 4'hF);
        a_rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstw_no_resp", 64'(a_resp_val), 64'd0);
        end
        a_reset_release_chk();

        // Round-robin: port0 wins first after reset; after a solo port0 grant, port1 wins.
        a_dual(32'h10, 32'h20, l0, l1, d0, d1);
        chk("rr1_lat0", 64'(l0), 64'd2);
        chk("rr1_lat1", 64'(l1), 64'd3);
        chk("rr1_data0_unchanged", 64'(d0), 64'hDEADBEEF);
        chk("rr1_data1", 64'(d1), 64'h11BB33DD);
        a_read_chk(0, 32'h10, 32'hDEADBEEF);
        a_dual(32'h10, 32'hFFFF_FF23, l0, l1, d0, d1);
        chk("rr2_lat0", 64'(l0), 64'd3);
        chk("rr2_lat1", 64'(l1), 64'd2);
        chk("rr2_data0", 64'(d0), 64'hDEADBEEF);
        chk("rr2_alias_data1", 64'(d1), 64'h11BB33DD);

        // Random traffic with delays on both ports, disjoint word ranges per port.
        for (int w = 0; w < 64; w++) begin
            mdl[w]  = '0;
            mvld[w] = '0;
        end
        for (int r = 0; r < 500; r++) begin
            logic        got;
            logic [1:0]  done;
            logic [1:0]  rw;
            int          wi   [2];
            int          lt;
            logic [31:0] rnd, dat, bm;
            logic [3:0]  wm;
            logic [5:0]  w6;

            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (b_req_rdy == 2'b11) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("rnd_idle", 64'(got), 64'd1);

            for (int p = 0; p < 2; p++) begin
                rw[p] = 1'($urandom_range(0, 1));
                wi[p] = p * 32 + int'($urandom_range(0, 31));
                w6    = 6'(wi[p]);
                rnd   = $urandom();
                dat   = $urandom();
                wm    = 4'($urandom_range(0, 15));
                b_rw[p]            = rw[p];
                b_addr[p*32 +: 32] = {rnd[31:8], w6, rnd[1:0]};
                b_data[p*32 +: 32] = dat;
                b_wmask[p*4 +: 4]  = wm;
                b_val[p]           = 1'b1;
                if (rw[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wm[b]) begin
                            mdl[wi[p]][b*8 +: 8] = dat[b*8 +: 8];
                            mvld[wi[p]][b]       = 1'b1;
                        end
                    end
                end
            end
            @(posedge clk);
            #1 b_val = 2'b00;

            done = 2'b00;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin
                    if (!done[p]) begin
                        if (rw[p] && b_req_rdy[p]) begin
                            done[p] = 1'b1;
                        end else if (!rw[p] && b_resp_val[p]) begin
                            done[p] = 1'b1;
                            lt = k;
                            bm = '0;
                            for (int b = 0; b < 4; b++)
                                if (mvld[wi[p]][b]) bm[b*8 +: 8] = 8'hFF;
                            chk("rnd_lat_in_range", 64'(lt >= 2 && lt <= 10), 64'd1);
                            chk("rnd_rdata", 64'(b_resp_data[p*32 +: 32] & bm),
                                64'(mdl[wi[p]] & bm));
                        end
                    end
                end
                if (done == 2'b11) break;
            end
            chk("rnd_complete", 64'(done), 64'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vc_mem_test_nport.md
VC_MEM_TEST_NPORT -- requirements
Module: vc_mem_test_nport

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of independent request/response ports (1..8).
REQ-002 SHALL have parameter MEM_SZ, default 8: physical byte-address width; array holds 2^(MEM_SZ-ADDR_SHIFT) words.
REQ-003 SHALL have parameter ADDR_SZ, default 32: request address width (ADDR_SZ >= MEM_SZ).
REQ-004 SHALL have parameter DATA_SZ, default 32: word width, multiple of 8.
REQ-005 SHALL have parameter ADDR_SHIFT, default 2: right shift applied to the address before indexing.
REQ-006 SHALL have parameter MAX_DELAY, default 0: maximum extra random delay per request, in cycles (0..65535).
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero base seed for the delay generators.
REQ-008 clk  input  1  sole clock; all state updates on rising edge.
REQ-009 reset_n  input  1  synchronous, active-low reset.
REQ-010 memreq_bits_rw  input  NUM_PORTS  per port: 0=read, 1=write.
REQ-011 memreq_bits_addr  input  NUM_PORTS*ADDR_SZ  per-port byte address; port p occupies slice [p*ADDR_SZ +: ADDR_SZ].
REQ-012 memreq_bits_data  input  NUM_PORTS*DATA_SZ  per-port write data.
REQ-013 memreq_bits_wmask  input  NUM_PORTS*DATA_SZ/8  per-port byte write enables.
REQ-014 memreq_val / memreq_rdy  input / output  NUM_PORTS each  per-port request handshake.
REQ-015 memresp_bits_data  output  NUM_PORTS*DATA_SZ  per-port read data.
REQ-016 memresp_val / memresp_rdy  output / input  NUM_PORTS each  per-port response handshake.

Function
REQ-017 Each port SHALL run an independent FSM with states IDLE, WAIT, RESP.
REQ-018 IDLE: memreq_rdy=1; on memreq_val, latch rw/addr/data/wmask, load the delay counter with lfsr[p] % (MAX_DELAY+1), and go to WAIT.
REQ-019 WAIT: memreq_rdy=0; counter nonzero -> decrement; counter zero -> request the array.
REQ-020 The array SHALL be accessed by at most one port per cycle; a round-robin arbiter grants among requesting ports, starting the search at the port after the last granted; rr pointer resets to 0.
REQ-021 Granted read: register m[addr[MEM_SZ-1:ADDR_SHIFT]] into the port's response register, then go to RESP.
REQ-022 Granted write: update only the bytes whose wmask bit is 1, generate no response, then go to IDLE.
REQ-023 Ungranted port stays in WAIT with counter at zero; no starvation (worst-case wait of NUM_PORTS-1 cycles).
REQ-024 RESP: memresp_val=1 with stable data until memresp_rdy=1, then go to IDLE; memreq_rdy=0 in RESP.
REQ-025 Minimum read latency SHALL be 2 cycles (accept in cycle N, memresp_val in cycle N+2); each delay cycle and each lost arbitration adds 1 cycle.
REQ-026 Address bits above MEM_SZ-1 and below ADDR_SHIFT SHALL be ignored (aliasing, no error).
REQ-027 Per-port 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1), seeded to LFSR_SEED ^ p, SHALL advance only on that port's request acceptance.
REQ-028 With MAX_DELAY=0 the loaded count SHALL always be 0.
REQ-029 Read and write granted in consecutive cycles to the same word: the read SHALL return post-write data; a write never coincides with a read (single grant).
REQ-030 memresp_bits_data SHALL hold its last value outside RESP.

Reset
REQ-031 While reset_n=0 at a clk edge: all FSMs to IDLE, counters 0, LFSRs reseeded, rr pointer 0, response registers 0.
REQ-032 After reset: memreq_rdy all 1, memresp_val all 0.
REQ-033 Reset mid-operation SHALL drop in-flight requests with no write or response; array contents are not reset.

Verification
REQ-034 MAX_DELAY=0, port0: write addr 0x10, data 0xDEADBEEF, wmask 4'hF; then read 0x10 -> memresp_val[0] two cycles after acceptance, data 0xDEADBEEF.
REQ-035 Byte mask: write 0x11223344 to 0x20, then write 0xAABBCCDD with wmask 4'b0101; read 0x20 -> 0x11BB33DD.
REQ-036 Both ports issue a read in the same cycle after reset -> port0 response at N+2 and port1 at N+3; repeat -> port1 first (round-robin).
REQ-037 Backpressure: hold memresp_rdy[0]=0 for 5 cycles -> memresp_val[0] and data stable, memreq_rdy[0]=0 throughout; one cycle after memresp_rdy rises, memreq_rdy[0]=1.
REQ-038 MAX_DELAY=7, 1000 random reads/writes on both ports against a reference model -> all data match, every latency between 2 and 2+7+(NUM_PORTS-1).
REQ-039 Assert reset_n=0 while port0 is in WAIT with a pending write -> target word unchanged, no memresp_val, memreq_rdy=1 after release.
